// File: rtl/decode_stage.sv
// Registered MIPS-subset decode stage with a valid/ready handshake on both sides,
// load-use bubble insertion and a running count of bundles handed downstream.
module decode_stage #(
  parameter int HAZARD_EN = 1,
  parameter int CNT_W     = 16,
  parameter int IMM_SEXT  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [31:0]      imm,
  output logic [25:0]      adr,
  output logic [3:0]       aluOp,
  output logic             regwrite,
  output logic             memread,
  output logic             memwrite,
  output logic             immReg,
  output logic             jump,
  output logic             illegal,
  output logic [CNT_W-1:0] dec_count
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_PEND = 2'd1,
    BUBBLE    = 2'd2
  } haz_state_e;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [25:0] adr;
    logic [3:0]  alu_op;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        imm_reg;
    logic        jump;
    logic        illegal;
  } bundle_t;

  logic [5:0] opcode;
  logic [5:0] funct;
  bundle_t    dec_bundle;

  bundle_t          bundle_d,    bundle_q;
  logic             out_valid_d, out_valid_q;
  logic [CNT_W-1:0] dec_count_d, dec_count_q;
  haz_state_e       haz_state_d, haz_state_q;
  logic [4:0]       lw_rd_d,     lw_rd_q;

  logic is_lw;
  logic reads_rs;
  logic reads_rt;
  logic dependent;
  logic bubble;
  logic in_ready_int;
  logic in_fire;
  logic out_fire;

  assign opcode = instruction[31:26];
  assign funct  = instruction[5:0];

  // NOTE: every field gets a default before the case so no path leaves a latch behind.
  always_comb begin
    dec_bundle     = '0;
    dec_bundle.rs  = instruction[25:21];
    dec_bundle.rt  = instruction[20:16];
    dec_bundle.adr = instruction[25:0];
    dec_bundle.imm = (IMM_SEXT != 0) ? {{16{instruction[15]}}, instruction[15:0]}
                                     : {16'h0000, instruction[15:0]};
    case (opcode)
      OP_RTYPE: begin
        dec_bundle.rd       = instruction[15:11];
        dec_bundle.regwrite = 1'b1;
        case (funct)
          FN_ADD:  dec_bundle.alu_op = ALU_ADD;
          FN_SUB:  dec_bundle.alu_op = ALU_SUB;
          FN_AND:  dec_bundle.alu_op = ALU_AND;
          FN_OR:   dec_bundle.alu_op = ALU_OR;
          FN_SLT:  dec_bundle.alu_op = ALU_SLT;
          default: begin
            dec_bundle.regwrite = 1'b0;
            dec_bundle.illegal  = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        dec_bundle.rd       = instruction[20:16];
        dec_bundle.regwrite = 1'b1;
        dec_bundle.imm_reg  = 1'b1;
      end
      OP_LW: begin
        dec_bundle.rd       = instruction[20:16];
        dec_bundle.regwrite = 1'b1;
        dec_bundle.memread  = 1'b1;
        dec_bundle.imm_reg  = 1'b1;
      end
      OP_SW: begin
        dec_bundle.memwrite = 1'b1;
        dec_bundle.imm_reg  = 1'b1;
      end
      OP_J:    dec_bundle.jump    = 1'b1;
      default: dec_bundle.illegal = 1'b1;
    endcase
  end

  // A pending load only hazards on registers the offered instruction actually reads.
  always_comb begin
    is_lw     = (opcode == OP_LW);
    reads_rs  = (opcode != OP_J);
    reads_rt  = (opcode == OP_RTYPE) || (opcode == OP_SW);
    dependent = (lw_rd_q != 5'd0) &&
                ((reads_rs && (dec_bundle.rs == lw_rd_q)) ||
                 (reads_rt && (dec_bundle.rt == lw_rd_q)));
    bubble    = (HAZARD_EN != 0) && (haz_state_q == LOAD_PEND) && in_valid && dependent;
    in_ready_int = !rst && (!out_valid_q || out_ready) && !bubble;
    in_fire   = in_valid && in_ready_int;
    out_fire  = out_valid_q && out_ready;
  end

  always_comb begin
    haz_state_d = haz_state_q;
    lw_rd_d     = lw_rd_q;
    case (haz_state_q)
      IDLE: begin
        if (in_fire && is_lw) begin
          haz_state_d = LOAD_PEND;
          lw_rd_d     = dec_bundle.rd;
        end
      end
      LOAD_PEND: begin
        // Leave for BUBBLE only once the load has gone (or is going) downstream.
        if (bubble && (out_fire || !out_valid_q)) begin
          haz_state_d = BUBBLE;
          lw_rd_d     = 5'd0;
        end else if (in_fire) begin
          haz_state_d = is_lw ? LOAD_PEND : IDLE;
          lw_rd_d     = is_lw ? dec_bundle.rd : 5'd0;
        end
      end
      BUBBLE: begin
        // A load accepted on the cycle after a bubble must still be remembered.
        haz_state_d = (in_fire && is_lw) ? LOAD_PEND : IDLE;
        lw_rd_d     = (in_fire && is_lw) ? dec_bundle.rd : 5'd0;
      end
      default: begin
        haz_state_d = IDLE;
        lw_rd_d     = 5'd0;
      end
    endcase
  end

  always_comb begin
    bundle_d    = in_fire ? dec_bundle : bundle_q;
    out_valid_d = in_fire ? 1'b1 : (out_fire ? 1'b0 : out_valid_q);
    dec_count_d = out_fire ? dec_count_q + CNT_W'(1) : dec_count_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      bundle_q    <= '0;
      out_valid_q <= 1'b0;
      dec_count_q <= '0;
      haz_state_q <= IDLE;
      lw_rd_q     <= 5'd0;
    end else begin
      bundle_q    <= bundle_d;
      out_valid_q <= out_valid_d;
      dec_count_q <= dec_count_d;
      haz_state_q <= haz_state_d;
      lw_rd_q     <= lw_rd_d;
    end
  end

  assign in_ready  = in_ready_int;
  assign out_valid = out_valid_q;
  assign rs        = bundle_q.rs;
  assign rt        = bundle_q.rt;
  assign rd        = bundle_q.rd;
  assign imm       = bundle_q.imm;
  assign adr       = bundle_q.adr;
  assign aluOp     = bundle_q.alu_op;
  assign regwrite  = bundle_q.regwrite;
  assign memread   = bundle_q.memread;
  assign memwrite  = bundle_q.memwrite;
  assign immReg    = bundle_q.imm_reg;
  assign jump      = bundle_q.jump;
  assign illegal   = bundle_q.illegal;
  assign dec_count = dec_count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: two instances (hazard/sign-extend on, and
// hazard/sign-extend off with a 4-bit counter) checked against a bundle scoreboard.
module tb_decode_stage;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [25:0] adr;
    logic [3:0]  alu;
    logic [5:0]  flg;  // {regwrite, memread, memwrite, immReg, jump, illegal}
  } bundle_t;

  localparam logic [5:0] F_RW   = 6'b100000;
  localparam logic [5:0] F_ADDI = 6'b100100;
  localparam logic [5:0] F_LW   = 6'b110100;
  localparam logic [5:0] F_SW   = 6'b001100;
  localparam logic [5:0] F_J    = 6'b000010;
  localparam logic [5:0] F_ILL  = 6'b000001;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid    [2];
  logic        in_ready    [2];
  logic [31:0] instruction [2];
  logic        out_valid   [2];
  logic        out_ready   [2];
  logic [4:0]  rs [2];
  logic [4:0]  rt [2];
  logic [4:0]  rd [2];
  logic [31:0] imm [2];
  logic [25:0] adr [2];
  logic [3:0]  alu_op [2];
  logic        regwrite [2];
  logic        memread [2];
  logic        memwrite [2];
  logic        imm_reg [2];
  logic        jump [2];
  logic        illegal [2];
  logic [15:0] dec_count0;
  logic [3:0]  dec_count1;

  bundle_t     exp_q0[$];
  bundle_t     exp_q1[$];
  logic [15:0] exp_cnt0;
  logic [3:0]  exp_cnt1;
  bundle_t     cur_exp [2];
  logic        fired [2];
  int          stall_cnt [2];
  int          ov_low [2];
  int          checks = 0;
  int          errors = 0;

  decode_stage #(.HAZARD_EN(1), .CNT_W(16), .IMM_SEXT(1)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .instruction(instruction[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .rs(rs[0]), .rt(rt[0]), .rd(rd[0]), .imm(imm[0]), .adr(adr[0]), .aluOp(alu_op[0]),
    .regwrite(regwrite[0]), .memread(memread[0]), .memwrite(memwrite[0]),
    .immReg(imm_reg[0]), .jump(jump[0]), .illegal(illegal[0]), .dec_count(dec_count0)
  );

  decode_stage #(.HAZARD_EN(0), .CNT_W(4), .IMM_SEXT(0)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .instruction(instruction[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .rs(rs[1]), .rt(rt[1]), .rd(rd[1]), .imm(imm[1]), .adr(adr[1]), .aluOp(alu_op[1]),
    .regwrite(regwrite[1]), .memread(memread[1]), .memwrite(memwrite[1]),
    .immReg(imm_reg[1]), .jump(jump[1]), .illegal(illegal[1]), .dec_count(dec_count1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  function automatic bundle_t mk(input logic [4:0] r_s, input logic [4:0] r_t,
                                 input logic [4:0] r_d, input logic [31:0] im,
                                 input logic [25:0] ad, input logic [3:0] al,
                                 input logic [5:0] fl);
    return {r_s, r_t, r_d, im, ad, al, fl};
  endfunction

  function automatic bundle_t observed(input int d);
    return {rs[d], rt[d], rd[d], imm[d], adr[d], alu_op[d],
            regwrite[d], memread[d], memwrite[d], imm_reg[d], jump[d], illegal[d]};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input int d);
    bundle_t e;
    if (d == 0) begin
      check("sb0_pending", 128'(exp_q0.size() > 0), 128'(1));
      if (exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        check("sb0_bundle", 128'(observed(0)), 128'(e));
        check("sb0_count", 128'(dec_count0), 128'(exp_cnt0));
        exp_cnt0++;
      end
    end else begin
      check("sb1_pending", 128'(exp_q1.size() > 0), 128'(1));
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        check("sb1_bundle", 128'(observed(1)), 128'(e));
        check("sb1_count", 128'(dec_count1), 128'(exp_cnt1));
        exp_cnt1++;
      end
    end
  endtask

  // Handshakes are evaluated mid-cycle, for the edge that follows.
  task automatic tick();
    @(negedge clk);
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (in_valid[d] && !in_ready[d]) stall_cnt[d]++;
        if (!out_valid[d]) ov_low[d]++;
        if (out_valid[d] && out_ready[d]) pop_check(d);
        if (in_valid[d] && in_ready[d]) begin
          if (d == 0) exp_q0.push_back(cur_exp[0]);
          else        exp_q1.push_back(cur_exp[1]);
          fired[d] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [31:0] instr, input bundle_t e);
    instruction[d] = instr;
    in_valid[d]    = 1'b1;
    cur_exp[d]     = e;
    fired[d]       = 1'b0;
    for (int n = 0; n < 20 && !fired[d]; n++) tick();
    check($sformatf("accept_dut%0d_%08h", d, instr), 128'(fired[d]), 128'(1));
  endtask

  task automatic idle(input int d);
    in_valid[d] = 1'b0;
  endtask

  initial begin
    bundle_t add_b;
    rst = 1'b1;
    exp_cnt0 = '0;
    exp_cnt1 = '0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b0; instruction[d] = '0;
      fired[d] = 1'b0; stall_cnt[d] = 0; ov_low[d] = 0; cur_exp[d] = '0;
    end
    add_b = mk(5'd1, 5'd2, 5'd3, 32'h0000_1820, 26'h022_1820, 4'd0, F_RW);

    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_in_ready%0d", d), 128'(in_ready[d]), 128'(0));
      check($sformatf("rst_out_valid%0d", d), 128'(out_valid[d]), 128'(0));
      check($sformatf("rst_outputs%0d", d), 128'(observed(d)), 128'(0));
    end
    check("rst_count0", 128'(dec_count0), 128'(0));
    check("rst_count1", 128'(dec_count1), 128'(0));
    rst = 1'b0;
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    #1;
    check("post_rst_in_ready", 128'(in_ready[0]), 128'(1));

    // add $3,$1,$2 with one-cycle latency
    send(0, 32'h0022_1820, add_b);
    check("add_latency_valid", 128'(out_valid[0]), 128'(1));
    check("add_latency_bundle", 128'(observed(0)), 128'(add_b));
    idle(0);
    tick();
    check("add_count", 128'(dec_count0), 128'(1));

    // remaining R-type ops and addi (sign-extended) back to back
    send(0, 32'h0022_1822, mk(5'd1, 5'd2, 5'd3, 32'h0000_1822, 26'h022_1822, 4'd1, F_RW));
    send(0, 32'h0022_1824, mk(5'd1, 5'd2, 5'd3, 32'h0000_1824, 26'h022_1824, 4'd2, F_RW));
    send(0, 32'h0022_1825, mk(5'd1, 5'd2, 5'd3, 32'h0000_1825, 26'h022_1825, 4'd3, F_RW));
    send(0, 32'h0022_182A, mk(5'd1, 5'd2, 5'd3, 32'h0000_182A, 26'h022_182A, 4'd4, F_RW));
    send(0, 32'h2005_FFFF, mk(5'd0, 5'd5, 5'd5, 32'hFFFF_FFFF, 26'h005_FFFF, 4'd0, F_ADDI));
    check("addi_sext_imm", 128'(imm[0]), 128'(32'hFFFF_FFFF));
    check("addi_rd", 128'(rd[0]), 128'(5));
    idle(0);
    tick();

    // lw $4 then dependent add $6,$4,$2: one stall cycle, one empty output cycle
    send(0, 32'h8C24_0000, mk(5'd1, 5'd4, 5'd4, 32'h0, 26'h024_0000, 4'd0, F_LW));
    stall_cnt[0] = 0;
    ov_low[0]    = 0;
    send(0, 32'h0082_3020, mk(5'd4, 5'd2, 5'd6, 32'h0000_3020, 26'h082_3020, 4'd0, F_RW));
    idle(0);
    check("haz_stall_cycles", 128'(stall_cnt[0]), 128'(1));
    check("haz_gap_cycles", 128'(ov_low[0]), 128'(1));
    tick();

    // lw $0 never creates a hazard
    send(0, 32'h8C20_0000, mk(5'd1, 5'd0, 5'd0, 32'h0, 26'h020_0000, 4'd0, F_LW));
    stall_cnt[0] = 0;
    ov_low[0]    = 0;
    send(0, 32'h0002_3020, mk(5'd0, 5'd2, 5'd6, 32'h0000_3020, 26'h002_3020, 4'd0, F_RW));
    idle(0);
    check("r0_stall_cycles", 128'(stall_cnt[0]), 128'(0));
    check("r0_gap_cycles", 128'(ov_low[0]), 128'(0));
    tick();

    // illegal opcode still flows and counts
    send(0, 32'hFC00_0000, mk(5'd0, 5'd0, 5'd0, 32'h0, 26'h0, 4'd0, F_ILL));
    check("ill_flag", 128'(illegal[0]), 128'(1));
    check("ill_ctrl", 128'({regwrite[0], memwrite[0], memread[0]}), 128'(0));
    idle(0);
    tick();
    check("ill_count", 128'(dec_count0), 128'(11));

    // sw and j
    send(0, 32'hAC47_0008, mk(5'd2, 5'd7, 5'd0, 32'h0000_0008, 26'h047_0008, 4'd0, F_SW));
    send(0, 32'h0800_0123, mk(5'd0, 5'd0, 5'd0, 32'h0000_0123, 26'h000_0123, 4'd0, F_J));
    idle(0);
    tick();
    check("sw_j_count", 128'(dec_count0), 128'(13));

    // second instance: zero-extend, no hazard bubbles, 4-bit counter wrap
    send(1, 32'h2005_FFFF, mk(5'd0, 5'd5, 5'd5, 32'h0000_FFFF, 26'h005_FFFF, 4'd0, F_ADDI));
    check("addi_zext_imm", 128'(imm[1]), 128'(32'h0000_FFFF));
    send(1, 32'h8C24_0000, mk(5'd1, 5'd4, 5'd4, 32'h0, 26'h024_0000, 4'd0, F_LW));
    stall_cnt[1] = 0;
    ov_low[1]    = 0;
    send(1, 32'h0082_3020, mk(5'd4, 5'd2, 5'd6, 32'h0000_3020, 26'h082_3020, 4'd0, F_RW));
    check("nohaz_stall_cycles", 128'(stall_cnt[1]), 128'(0));
    check("nohaz_gap_cycles", 128'(ov_low[1]), 128'(0));
    for (int i = 0; i < 12; i++)
      send(1, 32'h0800_0123, mk(5'd0, 5'd0, 5'd0, 32'h0000_0123, 26'h000_0123, 4'd0, F_J));
    idle(1);
    tick();
    check("cnt_at_max", 128'(dec_count1), 128'(4'hF));
    send(1, 32'h0800_0123, mk(5'd0, 5'd0, 5'd0, 32'h0000_0123, 26'h000_0123, 4'd0, F_J));
    idle(1);
    tick();
    check("cnt_wrap", 128'(dec_count1), 128'(4'h0));

    // downstream stall holds the bundle; reset in the stall discards it
    out_ready[0] = 1'b0;
    send(0, 32'h0022_1820, add_b);
    idle(0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall_valid_%0d", i), 128'(out_valid[0]), 128'(1));
      check($sformatf("stall_bundle_%0d", i), 128'(observed(0)), 128'(add_b));
      check($sformatf("stall_in_ready_%0d", i), 128'(in_ready[0]), 128'(0));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    exp_cnt0 = '0;
    exp_cnt1 = '0;
    #1;
    check("rst_stall_valid", 128'(out_valid[0]), 128'(0));
    check("rst_stall_count", 128'(dec_count0), 128'(0));
    check("rst_stall_in_ready", 128'(in_ready[0]), 128'(1));
    check("rst_stall_outputs", 128'(observed(0)), 128'(0));

    out_ready[0] = 1'b1;
    send(0, 32'hAC47_0008, mk(5'd2, 5'd7, 5'd0, 32'h0000_0008, 26'h047_0008, 4'd0, F_SW));
    idle(0);
    tick();
    check("post_rst_count", 128'(dec_count0), 128'(1));

    check("sb0_drained", 128'(exp_q0.size()), 128'(0));
    check("sb1_drained", 128'(exp_q1.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL expose these parameters:
- HAZARD_EN, 1: load-use bubble insertion enabled.
- CNT_W, 16: width of the decoded-instruction counter.
- IMM_SEXT, 1: sign-extend (1) or zero-extend (0) imm to 32 bits.

REQ-002 The block SHALL expose these ports:
- clk  in  1  sole clock; all state rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  stage accepts instruction this cycle.
- instruction  in  32  instruction word.
- out_valid  out  1  decoded bundle held.
- out_ready  in  1  downstream accepts bundle.
- rs, rt, rd  out  5 each  source/source/destination register.
- imm  out  32  extended immediate.
- adr  out  26  jump target field.
- aluOp  out  4  ALU operation.
- regwrite, memread, memwrite, immReg, jump, illegal  out  1 each  control flags.
- dec_count  out  CNT_W  instructions handed downstream.

Function
REQ-003 The block SHALL take the field slices opcode=[31:26], rs=[25:21], rt=[20:16], R-type rd=[15:11], funct=[5:0], imm=[15:0], adr=[25:0].

REQ-004 The block SHALL assign the destination rd as follows: [15:11] for R-type; rt for addi and lw; 0 otherwise.

REQ-005 The block SHALL decode opcode 0x00 by funct:
- 0x20 add: aluOp 0.
- 0x22 sub: aluOp 1.
- 0x24 and: aluOp 2.
- 0x25 or: aluOp 3.
- 0x2A slt: aluOp 4.
- All five set regwrite=1 and immReg=0.

REQ-006 The block SHALL decode the remaining opcodes as:
- 0x08 addi: regwrite, immReg, aluOp 0.
- 0x23 lw: regwrite, memread, immReg, aluOp 0.
- 0x2B sw: memwrite, immReg, aluOp 0.
- 0x02 j: jump.

REQ-007 Any other opcode/funct SHALL set illegal=1, all other flags 0 and aluOp 0, while still passing through handshake.

REQ-008 Decode SHALL be registered: a bundle accepted at edge N SHALL appear with out_valid=1 after edge N (1-cycle latency).

REQ-009 An input transfer SHALL occur when in_valid && in_ready.

REQ-010 in_ready SHALL equal (!out_valid || out_ready) && !bubble.

REQ-011 The output register SHALL hold all outputs stable while out_valid && !out_ready.

REQ-012 out_valid SHALL clear after an output transfer with no new input transfer in the same cycle.

REQ-013 Simultaneous output and input transfers SHALL replace the bundle with no idle cycle.

REQ-014 Hazard tracking SHALL behave as follows:
- The stage SHALL remember whether the last transferred bundle was lw, and its rd.
- When HAZARD_EN=1, the offered instruction reads rs or rt equal to that rd, and rd≠0, bubble SHALL assert for exactly one cycle.
- During that bubble cycle out_valid SHALL drop to 0 once the lw transfers downstream, and the lw record SHALL clear.

REQ-015 The hazard state machine SHALL have states IDLE, LOAD_PEND and BUBBLE:
- IDLE->LOAD_PEND on lw input transfer.
- LOAD_PEND->BUBBLE on dependent offer.
- LOAD_PEND->IDLE on non-lw transfer.
- LOAD_PEND->LOAD_PEND on lw transfer.
- BUBBLE->IDLE next cycle.

REQ-016 An instruction "reads" rs for all non-j opcodes and reads rt for R-type and sw only.

REQ-017 dec_count SHALL increment by 1 on each output transfer, wrapping from 2^CNT_W-1 to 0; illegal bundles SHALL count.

REQ-018 When IMM_SEXT=1, imm SHALL equal {{16{instruction[15]}}, instruction[15:0]}; otherwise it SHALL be zero-extended.

REQ-019 The block SHALL contain no simulation-only display statements in synthesizable paths.

Reset
REQ-020 While rst=1 at a clock edge, the following SHALL hold:
- out_valid=0, hazard state IDLE, lw record cleared, dec_count=0.
- All data and flag outputs 0, in_ready=0.

REQ-021 Reset asserted mid-bubble or mid-stall SHALL discard the held bundle with no output transfer; in_ready SHALL be 1 the first cycle after rst deasserts.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- add $3,$1,$2 (0x00221820), out_ready=1 -> next cycle out_valid=1, rs=1, rt=2, rd=3, aluOp=0, regwrite=1, dec_count=1.
- addi $5,$0,-1 (0x2005FFFF), IMM_SEXT=1 -> imm=0xFFFFFFFF, rd=5, immReg=1; with IMM_SEXT=0 -> imm=0x0000FFFF.
- lw $4,0($1) then add $6,$4,$2 back-to-back -> in_ready low exactly one cycle, one out_valid=0 gap, add emitted after; with HAZARD_EN=0 no gap.
- lw $0,... followed by dependent on $0 -> no bubble.
- Opcode 0x3F -> illegal=1, regwrite=memwrite=memread=0, dec_count increments.
- out_ready=0 for 3 cycles with out_valid=1 -> outputs unchanged and in_ready=0; rst pulse in that window -> out_valid=0, dec_count=0 next cycle.
- dec_count at 2^CNT_W-1 plus one transfer -> 0.
